pc_fetch_unit: RTL and testbench

- Program-counter and next-PC stage directly upstream of the instruction memory in the single-cycle CPU.
- Holds the architectural PC and drives the instruction-memory address.
- Resolves sequential, branch, jump and jump-register redirects each cycle.
- Supports stall and halt, and flags misaligned jump-register targets.

---
 rtl/pc_fetch_unit.sv | 107 ++++++++++
 tb/tb_pc_fetch_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and next-PC selection ahead of instruction memory
// Optional PC_FETCH_PERF_EN adds fetch_count and redirect_count.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] rs_data,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        addr_err
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic        addr_err_n;
  logic        redirect;
  logic [31:0] branch_off;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= {RESET_PC[31:2], 2'b00};
      addr_err <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= {pc_n[31:2], 2'b00};
      addr_err <= addr_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    addr_err_n  = addr_err;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    redirect    = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        // Halt detect outranks every redirect; the zero word never executes.
        if (!stall) begin
          if (HALT_ON_ZERO && inst == 32'h0000_0000) begin
            state_n = HALT;
          end else begin
            fetch_valid = 1'b1;
            if (jr) begin
              redirect = 1'b1;
              pc_n     = {rs_data[31:2], 2'b00};
              if (rs_data[1:0] != 2'b00) addr_err_n = 1'b1;
            end else if (jump) begin
              redirect = 1'b1;
              pc_n     = {pc_plus4[31:28], inst[25:0], 2'b00};
            end else if (branch_taken) begin
              redirect = 1'b1;
              pc_n     = pc_plus4 + branch_off;
            end else begin
              pc_n = pc_plus4;
            end
          end
        end
      end
      HALT: begin
        halted = 1'b1;
        // Resume steps past the halting word.
        if (resume) begin
          state_n = RUN;
          pc_n    = pc_plus4;
        end
      end
      default: state_n = BOOT;
    endcase
  end

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count    <= 32'd0;
      redirect_count <= 32'd0;
    end else begin
      if (fetch_valid) fetch_count <= fetch_count + 32'd1;
      if (redirect)    redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, jr, resume;
  logic [31:0] inst, rs_data;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, halted, addr_err;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count, redirect_count;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .inst(inst),
    .branch_taken(branch_taken), .jump(jump), .jr(jr), .rs_data(rs_data),
    .resume(resume), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .halted(halted), .addr_err(addr_err)
`ifdef PC_FETCH_PERF_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        h;
    logic        e;
    bit          cnt0;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] IN = 32'h1234_5678;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] epc, input logic efv, input logic eh,
                          input logic ee, input bit cnt0 = 1'b0);
    exp_t x;
    x.pc = epc; x.fv = efv; x.h = eh; x.e = ee; x.cnt0 = cnt0;
    q.push_back(x);
  endtask

  task automatic cyc(input logic s, input logic [31:0] i, input logic b, input logic j,
                     input logic r, input logic [31:0] rs, input logic res,
                     input logic [31:0] epc, input logic efv, input logic eh, input logic ee);
    stall = s; inst = i; branch_taken = b; jump = j; jr = r; rs_data = rs; resume = res;
    push_exp(epc, efv, eh, ee);
    @(posedge clk); #1;
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check("pc", pc, x.pc);
      check("pc_plus4", pc_plus4, x.pc + 32'd4);
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, x.fv});
      check("halted", {31'd0, halted}, {31'd0, x.h});
      check("addr_err", {31'd0, addr_err}, {31'd0, x.e});
`ifdef PC_FETCH_PERF_EN
      if (x.cnt0) begin
        check("fetch_count", fetch_count, 32'd0);
        check("redirect_count", redirect_count, 32'd0);
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0; stall = 0; inst = IN; branch_taken = 0; jump = 0; jr = 0;
    rs_data = 0; resume = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    // boot bubble then sequential
    cyc(0, IN, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    cyc(0, IN, 0, 0, 0, 0, 0, 32'h00, 1, 0, 0);
    cyc(0, IN, 0, 0, 0, 0, 0, 32'h04, 1, 0, 0);
    cyc(0, IN, 0, 0, 0, 0, 0, 32'h08, 1, 0, 0);
    cyc(0, IN, 0, 0, 0, 0, 0, 32'h0C, 1, 0, 0);
    // backward branch
    cyc(0, 32'h0000_FFFC, 1, 0, 0, 0, 0, 32'h10, 1, 0, 0);
    for (int k = 0; k < 5; k++)
      cyc(0, IN, 0, 0, 0, 0, 0, 32'h04 + 32'(4 * k), 1, 0, 0);
    // halt on zero word, stall and redirects ignored while halted
    cyc(0, 32'h0, 1, 1, 0, 0, 0, 32'h18, 0, 0, 0);
    cyc(1, IN, 0, 0, 0, 0, 0, 32'h18, 0, 1, 0);
    cyc(0, IN, 1, 1, 0, 0, 0, 32'h18, 0, 1, 0);
    cyc(0, IN, 0, 0, 0, 0, 0, 32'h18, 0, 1, 0);
    cyc(0, IN, 0, 0, 0, 0, 1, 32'h18, 0, 1, 0);
    cyc(0, IN, 0, 0, 0, 0, 0, 32'h1C, 1, 0, 0);
    // priority: jr wins, misaligned target sets sticky addr_err
    cyc(0, IN, 1, 1, 1, 32'h103, 0, 32'h20, 1, 0, 0);
    for (int k = 0; k < 6; k++)
      cyc(0, IN, 0, 0, 0, 0, 0, 32'h100 + 32'(4 * k), 1, 0, 1);
    cyc(0, 32'h10, 0, 1, 0, 0, 0, 32'h118, 1, 0, 1);
    // stall holds pc and drops the jump
    for (int k = 0; k < 3; k++)
      cyc(1, 32'h10, 0, 1, 0, 0, 0, 32'h40, 0, 0, 1);
    cyc(0, 32'h10, 0, 1, 0, 0, 0, 32'h40, 1, 0, 1);
    // pc_plus4 wrap at top of address space
    cyc(0, IN, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h40, 1, 0, 1);
    cyc(0, IN, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 1);
    cyc(0, 32'hC, 0, 1, 0, 0, 0, 32'h00, 1, 0, 1);
    cyc(1, IN, 0, 0, 0, 0, 0, 32'h30, 0, 0, 1);
    // async reset between edges while stalled at 0x30
    stall = 1;
    rst_n = 1'b0;
    push_exp(32'h0, 0, 0, 0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
